// File: rtl/jellyvl_stream_pkg.sv
// Helpers shared by the stream register chain: where skid buffers go and how many there are.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package jellyvl_stream_pkg;

    // A skid buffer sits in front of stage i when the interval is non-zero and i lands on it.
    function automatic bit has_skid(input int i, input int skid_every);
        if (skid_every == 0) begin
            return 1'b0;
        end
        return (i % skid_every) == 0;
    endfunction

    // Total skid buffers in a chain; bounds the number of beats the chain can absorb.
    function automatic int skid_count(input int stages, input int skid_every);
        int n;
        n = 0;
        for (int i = 0; i < stages; i++) begin
            if (has_skid(i, skid_every)) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/jellyvl_stream_ff_chain_if.sv
// Valid/ready stream bundle carrying one payload word per beat.
// Latency: none (wires only).
// Backpressure: ready flows from the slave side back to the master side.
interface jellyvl_stream_ff_chain_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/jellyvl_stream_ff_stage.sv
// One chain element: optional registered-ready skid buffer followed by a forward register slice.
// Latency: 1 cycle (forward register); the skid buffer adds none when unstalled.
// Backpressure: with SKID the upstream ready is a flop; without it, ready is !valid || m_ready.
module jellyvl_stream_ff_stage #(
    parameter int                   DATA_BITS = 8,
    parameter bit                   SKID      = 1'b1,
    parameter logic [DATA_BITS-1:0] INIT_DATA = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 clear,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [1:0]           occupancy
);
    // Hand-off between the skid buffer (or the raw input) and the forward register.
    logic [DATA_BITS-1:0] mid_data;
    logic                 mid_valid;
    logic                 mid_ready;
    logic                 skid_hold;

    logic                 ff_valid;
    logic [DATA_BITS-1:0] ff_data;

    assign mid_ready = !ff_valid || m_ready;

    if (SKID) begin : g_skid
        logic                 sk_valid;
        logic                 sk_ready;
        logic [DATA_BITS-1:0] sk_data;

        // Park a beat that arrives while the forward register is stalled; ready comes back once it drains.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sk_valid <= 1'b0;
                sk_ready <= 1'b0;
                sk_data  <= INIT_DATA;
            end else if (cke) begin
                if (clear) begin
                    sk_valid <= 1'b0;
                    sk_ready <= 1'b1;
                    sk_data  <= INIT_DATA;
                end else if (sk_valid) begin
                    if (mid_ready) begin
                        sk_valid <= 1'b0;
                        sk_ready <= 1'b1;
                    end
                end else if (sk_ready && s_valid && !mid_ready) begin
                    sk_valid <= 1'b1;
                    sk_ready <= 1'b0;
                    sk_data  <= s_data;
                end else begin
                    sk_ready <= 1'b1;
                end
            end
        end

        // The parked beat goes first; otherwise an accepted input passes straight through.
        assign s_ready   = sk_ready;
        assign mid_valid = sk_valid || (sk_ready && s_valid);
        assign mid_data  = sk_valid ? sk_data : s_data;
        assign skid_hold = sk_valid;
    end else begin : g_direct
        assign s_ready   = mid_ready;
        assign mid_valid = s_valid;
        assign mid_data  = s_data;
        assign skid_hold = 1'b0;
    end

    // Forward slice: refill whenever empty or the current beat is leaving.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff_valid <= 1'b0;
            ff_data  <= INIT_DATA;
        end else if (cke) begin
            if (clear) begin
                ff_valid <= 1'b0;
                ff_data  <= INIT_DATA;
            end else if (mid_ready) begin
                ff_valid <= mid_valid;
                if (mid_valid) begin
                    ff_data <= mid_data;
                end
            end
        end
    end

    assign m_valid   = ff_valid;
    assign m_data    = ff_data;
    assign occupancy = {1'b0, skid_hold} + {1'b0, ff_valid};

endmodule

// File: rtl/jellyvl_stream_ff_chain.sv
// Multi-stage valid/ready register chain with periodic skid buffers, synchronous flush and occupancy count.
// Latency: STAGES cycles from accept to m_valid when unstalled; 1 beat/cycle throughput.
// Backpressure: absorbs STAGES + skid-buffer beats; s_ready is gated low in reset, with cke low or during clear.
module jellyvl_stream_ff_chain
    import jellyvl_stream_pkg::*;
#(
    parameter int                   DATA_BITS  = 8,
    parameter int                   STAGES     = 2,
    parameter int                   SKID_EVERY = 1,
    parameter logic [DATA_BITS-1:0] INIT_DATA  = '0,
    parameter int                   CNT_BITS   = $clog2(2*STAGES+1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cke,
    input  logic                      clear,
    jellyvl_stream_ff_chain_if.slave  s,
    jellyvl_stream_ff_chain_if.master m,
    output logic [CNT_BITS-1:0]       count
);
    localparam int MAX_BEATS = STAGES + skid_count(STAGES, SKID_EVERY);
    localparam int SUM_BITS  = $clog2(MAX_BEATS + 1);

    logic [2*STAGES-1:0] occ_all;
    logic [SUM_BITS-1:0] occ_sum;

    // Each stage keeps its own link signals so the ready chain stays a set of independent nets.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [DATA_BITS-1:0] up_data;
        logic                 up_valid;
        logic                 up_ready;
        logic [DATA_BITS-1:0] dn_data;
        logic                 dn_valid;
        logic                 dn_ready;
        logic [1:0]           occ;

        if (i == 0) begin : g_head
            assign up_data  = s.data;
            assign up_valid = s.valid;
        end else begin : g_link
            assign up_data  = g_stage[i-1].dn_data;
            assign up_valid = g_stage[i-1].dn_valid;
        end

        if (i == STAGES - 1) begin : g_tail
            assign dn_ready = m.ready;
        end else begin : g_body
            assign dn_ready = g_stage[i+1].up_ready;
        end

        jellyvl_stream_ff_stage #(
            .DATA_BITS (DATA_BITS),
            .SKID      (has_skid(i, SKID_EVERY)),
            .INIT_DATA (INIT_DATA)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .cke       (cke),
            .clear     (clear),
            .s_data    (up_data),
            .s_valid   (up_valid),
            .s_ready   (up_ready),
            .m_data    (dn_data),
            .m_valid   (dn_valid),
            .m_ready   (dn_ready),
            .occupancy (occ)
        );

        assign occ_all[2*i +: 2] = occ;
    end

    // Occupancy is the popcount of every valid flop in the chain (forward slices plus skid buffers).
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + SUM_BITS'(occ_all[2*i +: 2]);
        end
    end

    assign count = CNT_BITS'(occ_sum);

    // Upstream may only hand over a beat when the chain is live: out of reset, enabled and not flushing.
    assign s.ready = reset && cke && !clear && g_stage[0].up_ready;
    // A flush cycle presents nothing downstream; in-flight beats are being discarded.
    assign m.valid = g_stage[STAGES-1].dn_valid && !clear;
    assign m.data  = g_stage[STAGES-1].dn_data;

endmodule

// File: tb/tb_jellyvl_stream_ff_chain.sv
// Directed bench for the stream register chain: three instances cover skid, no-skid and flush behaviour.
// Latency: checks the STAGES-cycle forward latency and back-to-back throughput.
// Backpressure: checks absorption depth, chained ready and cke freeze.
module tb_jellyvl_stream_ff_chain;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic cke_a = 1'b1;
    logic clear_c = 1'b0;

    always #5 clk = ~clk;

    jellyvl_stream_ff_chain_if #(.DATA_BITS(8)) sa ();
    jellyvl_stream_ff_chain_if #(.DATA_BITS(8)) ma ();
    jellyvl_stream_ff_chain_if #(.DATA_BITS(8)) sb ();
    jellyvl_stream_ff_chain_if #(.DATA_BITS(8)) mb ();
    jellyvl_stream_ff_chain_if #(.DATA_BITS(8)) sc ();
    jellyvl_stream_ff_chain_if #(.DATA_BITS(8)) mc ();

    logic [2:0] ca;
    logic [3:0] cb;
    logic [2:0] cc;

    jellyvl_stream_ff_chain #(.DATA_BITS(8), .STAGES(3), .SKID_EVERY(1)) u_dut_a (
        .clk(clk), .reset(reset), .cke(cke_a), .clear(1'b0), .s(sa), .m(ma), .count(ca));

    jellyvl_stream_ff_chain #(.DATA_BITS(8), .STAGES(4), .SKID_EVERY(0)) u_dut_b (
        .clk(clk), .reset(reset), .cke(1'b1), .clear(1'b0), .s(sb), .m(mb), .count(cb));

    jellyvl_stream_ff_chain #(.DATA_BITS(8), .STAGES(2), .SKID_EVERY(1)) u_dut_c (
        .clk(clk), .reset(reset), .cke(1'b1), .clear(clear_c), .s(sc), .m(mc), .count(cc));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];
    int acc_a = 0, del_a = 0;
    int t_acc1 = -1, t_del1 = -1, t_del16 = -1;
    int occ_b = 0, del_b = 0;
    bit b_done = 1'b0;

    // Scoreboards sample half a cycle away from the active edge; a handshake seen here commits at the next edge.
    always @(negedge clk) begin
        if (reset && cke_a) begin
            if (sa.valid && sa.ready) begin
                q_a.push_back(sa.data);
                acc_a++;
                if (sa.data == 8'h01) t_acc1 = cyc;
            end
            if (ma.valid && ma.ready) begin
                if (q_a.size() == 0) chk("a_extra_beat", 32'(q_a.size()), 1);
                else chk("a_order", 32'(ma.data), 32'(q_a.pop_front()));
                del_a++;
                if (ma.data == 8'h01) t_del1 = cyc;
                if (ma.data == 8'h10) t_del16 = cyc;
            end
        end
        if (reset) begin
            chk("b_chain_ready", 32'(sb.ready), 32'((occ_b < 4) || mb.ready));
            chk("b_count", 32'(cb), occ_b);
            if (sb.valid && sb.ready) begin
                q_b.push_back(sb.data);
                occ_b++;
            end
            if (mb.valid && mb.ready) begin
                if (q_b.size() == 0) chk("b_extra_beat", 32'(q_b.size()), 1);
                else chk("b_order", 32'(mb.data), 32'(q_b.pop_front()));
                occ_b--;
                del_b++;
            end
        end
        if (reset && clear_c) begin
            q_c.delete();
        end else if (reset) begin
            if (sc.valid && sc.ready) q_c.push_back(sc.data);
            if (mc.valid && mc.ready) begin
                if (q_c.size() == 0) chk("c_extra_beat", 32'(q_c.size()), 1);
                else chk("c_order", 32'(mc.data), 32'(q_c.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d);
        int n;
        n = 0;
        sa.valid = 1'b1;
        sa.data  = d;
        @(negedge clk);
        while (!sa.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_push_ready", 32'(sa.ready), 1);
        step();
        sa.valid = 1'b0;
    endtask

    task automatic push_c(input logic [7:0] d);
        int n;
        n = 0;
        sc.valid = 1'b1;
        sc.data  = d;
        @(negedge clk);
        while (!sc.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("c_push_ready", 32'(sc.ready), 1);
        step();
        sc.valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, del0, n;
        logic took;
        sa.valid = 1'b0; sa.data = '0; ma.ready = 1'b0;
        sb.valid = 1'b0; sb.data = '0; mb.ready = 1'b0;
        sc.valid = 1'b0; sc.data = '0; mc.ready = 1'b0;

        // Reset: ready gated low, nothing held, first ready one cycle after release.
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(sa.ready), 0);
        chk("rst_m_valid", 32'(ma.valid), 0);
        chk("rst_count", 32'(ca), 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rel_s_ready_first", 32'(sa.ready), 0);
        @(negedge clk);
        chk("rel_s_ready_next", 32'(sa.ready), 1);
        chk("rel_count", 32'(ca), 0);
        step();

        // Streaming: 16 beats back-to-back with the sink always ready.
        ma.ready = 1'b1;
        for (int d = 1; d <= 16; d++) push_a(8'(d));
        repeat (10) step();
        chk("a_latency", t_del1 - t_acc1, 3);
        chk("a_back_to_back", t_del16 - t_del1, 15);
        chk("a_stream_delivered", del_a, 16);

        // Backpressure: sink stalled, source streams continuously.
        ma.ready = 1'b0;
        acc0 = acc_a;
        sa.valid = 1'b1;
        sa.data  = 8'h40;
        repeat (20) begin
            @(negedge clk);
            took = sa.ready;
            step();
            if (took) sa.data = sa.data + 8'h01;
        end
        sa.valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", acc_a - acc0, 6);
        chk("bp_count", 32'(ca), 6);
        chk("bp_s_ready", 32'(sa.ready), 0);
        chk("bp_m_valid", 32'(ma.valid), 1);
        chk("bp_m_data", 32'(ma.data), 32'h40);
        step();
        del0 = del_a;
        ma.ready = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chk("bp_drained", del_a - del0, 6);
        chk("bp_count_empty", 32'(ca), 0);
        step();

        // cke freeze mid-stream: state and outputs hold, then the stream resumes in order.
        del0 = del_a;
        for (int d = 8'h80; d <= 8'h83; d++) push_a(8'(d));
        sa.valid = 1'b1;
        sa.data  = 8'h84;
        cke_a    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("frz_s_ready", 32'(sa.ready), 0);
            chk("frz_m_valid", 32'(ma.valid), 1);
            chk("frz_m_data", 32'(ma.data), 32'h81);
            chk("frz_count", 32'(ca), 3);
            step();
        end
        cke_a = 1'b1;
        for (int d = 8'h84; d <= 8'h87; d++) push_a(8'(d));
        repeat (10) step();
        @(negedge clk);
        chk("frz_delivered", del_a - del0, 8);
        chk("frz_queue_empty", 32'(q_a.size()), 0);
        step();

        // Clear: three beats held, one flush pulse, then a fresh beat is first out.
        for (int d = 1; d <= 3; d++) push_c(8'(8'h11 * d));
        @(negedge clk);
        chk("c_held_count", 32'(cc), 3);
        chk("c_held_m_data", 32'(mc.data), 32'h11);
        step();
        clear_c = 1'b1;
        @(negedge clk);
        chk("c_clr_m_valid", 32'(mc.valid), 0);
        chk("c_clr_s_ready", 32'(sc.ready), 0);
        step();
        clear_c = 1'b0;
        @(negedge clk);
        chk("c_post_count", 32'(cc), 0);
        chk("c_post_m_valid", 32'(mc.valid), 0);
        chk("c_post_m_data", 32'(mc.data), 0);
        chk("c_post_s_ready", 32'(sc.ready), 1);
        step();
        mc.ready = 1'b1;
        push_c(8'hA5);
        n = 0;
        @(negedge clk);
        while (!mc.valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("c_first_after_clear", 32'(mc.data), 32'hA5);
        step();

        // No-skid chain: 1000 random beats against a sink that is ready half the time.
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    int w;
                    w = 0;
                    sb.data  = 8'($urandom);
                    sb.valid = 1'b1;
                    @(negedge clk);
                    while (!sb.ready && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                    chk("b_push_ready", 32'(sb.ready), 1);
                    step();
                    sb.valid = 1'b0;
                    if ($urandom_range(0, 3) == 0) step();
                end
                b_done = 1'b1;
            end
            begin
                while (!b_done) begin
                    mb.ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        mb.ready = 1'b1;
        repeat (20) step();
        @(negedge clk);
        chk("b_delivered", del_b, 1000);
        chk("b_queue_empty", 32'(q_b.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jellyvl_stream_ff_chain.md
Name: jellyvl_stream_ff_chain

Overview:
- Parametrised multi-stage valid/ready register chain for stream pipelines. Inserts STAGES full-throughput forward register slices.
- Optional skid buffers are placed at a fixed interval to cut the combinational ready path.
- Adds synchronous flush (clear) and an occupancy count.
- Drop-in wherever long routes or timing-critical stream paths need more than one register slice.

Parameters:
- DATA_BITS, 8: payload width.
- STAGES, 2: number of forward register stages. Legal range 1..16.
- SKID_EVERY, 1: a skid buffer precedes stage i when SKID_EVERY!=0 and i%SKID_EVERY==0. Value 0 means no skid buffers.
- INIT_DATA, '0: data register and skid buffer value at reset and clear.
- CNT_BITS, $clog2(2*STAGES+1): width of the occupancy count.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- cke  input  1  clock enable. All state is frozen when low.
- clear  input  1  synchronous flush of all in-flight beats.
- s_data  input  DATA_BITS  upstream payload.
- s_valid  input  1  upstream valid.
- s_ready  output  1  upstream ready.
- m_data  output  DATA_BITS  downstream payload.
- m_valid  output  1  downstream valid.
- m_ready  input  1  downstream ready.
- count  output  CNT_BITS  number of beats currently held (register stages plus skid buffers).

Behaviour:
- Reset (reset==0, async):
  - All stage valids and skid valids go to 0; data goes to INIT_DATA.
  - Skid ready registers go to 0.
  - s_ready is forced to 0 combinationally while reset==0. m_valid=0, count=0.
- Skid ready registers reach 1 on the first cke cycle after reset release. So s_ready first rises one cycle after release when stage 0 has a skid buffer.
- Transfer rules:
  - A transfer occurs on a rising clk edge with cke=1, clear=0 and valid&&ready on that port.
  - m_valid and m_data stay stable until accepted. Beat order is preserved, with no loss and no duplication.
- Forward stage:
  - Loads on (!valid || next_ready).
  - Its ready is (!valid || next_ready), purely combinational toward upstream.
- Skid buffer:
  - Registered ready. Captures the incoming beat when it is not buffered, s_valid=1 and downstream is not ready; ready then drops the next cycle.
  - Presents the buffered beat first. Releases and reasserts ready when downstream accepts it.
  - Adds 0 latency when unstalled.
- Latency: an accepted beat appears on m_valid exactly STAGES cycles later when unstalled. Throughput is 1 beat/cycle with m_ready held high.
- Backpressure: with m_ready=0, the chain absorbs up to STAGES + (number of skid buffers) beats before s_ready=0.
- Ready path: the longest combinational ready path is SKID_EVERY stages; the whole chain when SKID_EVERY=0.
- cke=0:
  - No state updates. s_ready is forced to 0.
  - m_valid and m_data hold; no m-side transfer occurs (the sink shares cke).
- clear=1 (cke=1):
  - s_ready=0 and m_valid=0 combinationally during that cycle.
  - Next cycle, all valids are 0, data is INIT_DATA, count=0, and skid ready is 1.
  - clear held for multiple cycles keeps the chain empty.
- clear with cke=0: ignored until a cke=1 cycle.
- count is the combinational popcount of all valid registers. It never exceeds STAGES + skid count.
- Reset asserted mid-stream: in-flight beats are discarded immediately. No partial output follows.

Decomposition:
- Package jellyvl_stream_pkg holds:
  - function skid_count(STAGES, SKID_EVERY).
  - function has_skid(i, SKID_EVERY).
- One sub-module, jellyvl_stream_ff_stage, with parameters DATA_BITS, SKID (bit) and INIT_DATA. It contains one optional skid buffer plus one forward register and exposes per-stage occupancy (0..2).
- The top level generates STAGES instances, chains ready/valid, sums occupancies and applies the reset/clear/cke output gating.

Test Plan:
- Reset: STAGES=3, SKID_EVERY=1. Hold reset=0 for 5 cycles, then release -> s_ready=0 and m_valid=0 during reset; s_ready=1 one cycle after release; count=0.
- Streaming: STAGES=3, m_ready=1. Send 0x01..0x10 back-to-back -> 0x01 appears 3 cycles after its accept, then 16 consecutive beats in order.
- Backpressure: STAGES=3, SKID_EVERY=1, m_ready=0. Stream continuously -> s_ready drops after exactly 6 accepted beats and count=6. Raising m_ready then drains all 6 in order.
- No skid: SKID_EVERY=0, STAGES=4, random m_ready at 50%, 1000 random beats -> scoreboard matches with no loss, duplication or reorder. s_ready equals the chained ready every cycle.
- Clear: STAGES=2 with 3 beats held. Pulse clear for 1 cycle -> m_valid=0 that cycle, count=0 next cycle. The next beat sent (0xA5) is the first beat out.
- cke freeze: mid-stream, deassert cke for 4 cycles -> s_ready=0; m_valid and m_data held constant; count unchanged. The stream resumes in order with no lost beats.
